// File: rtl/jt51_i2s_tx.sv
// jt51_i2s_tx: I2S serial transmitter for the JT51 L/R sample pairs.
// Double-buffered: one pending pair plus the pair being sent. When no new
// pair is pending at frame start, the last pair is repeated.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sample_vld        1-clk strobe capturing left/right into the pending slot
//   left, right       signed 16-bit samples
//   bclk, lrclk       serial bit clock and word select (0=left, 1=right)
//   sdata             serial data, MSB first, changes on bclk falling edge
//   underrun/overrun  1-clk event pulses
//   ovr_cnt           saturating overrun count (JT51_I2S_OVRCNT_EN only)
// Optional feature macro: JT51_I2S_OVRCNT_EN
module jt51_i2s_tx #(
    parameter int BCLK_DIV = 4,
    parameter int SLOT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_vld,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        overrun
`ifdef JT51_I2S_OVRCNT_EN
    ,
    output logic [7:0]  ovr_cnt
`endif
);

    localparam int HALF = BCLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int NBIT = 2 * SLOT;
    localparam int BW   = $clog2(NBIT);

    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBIT - 1);
    localparam logic [BW-1:0] LR_ON    = BW'(SLOT - 1);
    localparam logic [BW-1:0] LR_OFF   = BW'(NBIT - 2);
    localparam logic [BW-1:0] R_START  = BW'(SLOT);
    localparam logic [BW-1:0] WORD     = BW'(16);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] r_off;
    logic [15:0]   sh_l;
    logic [15:0]   sh_r;
    logic [15:0]   pend_l;
    logic [15:0]   pend_r;
    logic          pend_vld;

    logic div_wrap;
    logic fall;
    logic frame_start;
    logic und_set;
    logic ovr_set;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign fall        = div_wrap & bclk;
    assign frame_start = fall & (bit_cnt == BIT_LAST);

    // A strobe on the frame-start clk only refills the slot the frame
    // just emptied, so it never counts as an overrun.
    assign und_set = frame_start & ~pend_vld;
    assign ovr_set = sample_vld & pend_vld & ~frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_LAST;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                bclk <= ~bclk;
            if (fall)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Transmit pair doubles as the repeat source on underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_l <= '0;
            sh_r <= '0;
        end else if (frame_start && pend_vld) begin
            sh_l <= pend_l;
            sh_r <= pend_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_l   <= '0;
            pend_r   <= '0;
            pend_vld <= 1'b0;
        end else if (sample_vld) begin
            pend_l   <= left;
            pend_r   <= right;
            pend_vld <= 1'b1;
        end else if (frame_start) begin
            pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= und_set;
            overrun  <= ovr_set;
        end
    end

`ifdef JT51_I2S_OVRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_cnt <= '0;
        else if (ovr_set && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 8'd1;
    end
`endif

    // lrclk and sdata decode straight from registered state, so they
    // follow the async reset in the same cycle.
    assign r_off = bit_cnt - R_START;
    assign lrclk = (bit_cnt >= LR_ON) && (bit_cnt <= LR_OFF);

    always_comb begin
        sdata = 1'b0;
        if (bit_cnt < WORD)
            sdata = sh_l[~bit_cnt[3:0]];
        else if (bit_cnt >= R_START && r_off < WORD)
            sdata = sh_r[~r_off[3:0]];
    end

endmodule

// File: tb/tb_jt51_i2s_tx.sv
// tb_jt51_i2s_tx: frame-level directed checks of jt51_i2s_tx.
// Captures each 128-clk frame and compares it with hand-computed values.
module tb_jt51_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sample_vld = 1'b0;
    logic [15:0] left = '0;
    logic [15:0] right = '0;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
    logic        overrun;
`ifdef JT51_I2S_OVRCNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jt51_i2s_tx #(.BCLK_DIV(4), .SLOT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_vld (sample_vld),
        .left       (left),
        .right      (right),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .underrun   (underrun),
        .overrun    (overrun)
`ifdef JT51_I2S_OVRCNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    typedef struct {
        int          j0;
        logic [15:0] l0;
        logic [15:0] r0;
        int          j1;
        logic [15:0] l1;
        logic [15:0] r1;
        logic [15:0] el;
        logic [15:0] er;
        logic        eu;
        int          eo;
    } frame_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Called at the negedge right after a frame-start edge (j=0).
    // Returns at j=0 of the following frame.
    task automatic run_frame(input string tag, input frame_t f);
        logic [31:0] d;
        logic [31:0] lr;
        logic        eb;
        int          bclk_err;
        int          und0;
        int          und_other;
        int          ovr;
        d = '0;
        lr = '0;
        bclk_err = 0;
        und0 = 0;
        und_other = 0;
        ovr = 0;
        for (int j = 0; j < 128; j++) begin
            eb = ((j % 4) >= 2);
            if (bclk !== eb)
                bclk_err++;
            if ((j % 4) == 1) begin
                d[31 - j / 4]  = sdata;
                lr[31 - j / 4] = lrclk;
            end
            if (underrun === 1'b1) begin
                if (j == 0)
                    und0 = 1;
                else
                    und_other++;
            end
            if (overrun === 1'b1)
                ovr++;
            sample_vld = 1'b0;
            if (j == f.j0) begin
                sample_vld = 1'b1;
                left = f.l0;
                right = f.r0;
            end else if (j == f.j1) begin
                sample_vld = 1'b1;
                left = f.l1;
                right = f.r1;
            end
            @(negedge clk);
        end
        sample_vld = 1'b0;
        chk({tag, ".data"}, d, {f.el, f.er});
        chk({tag, ".lrclk"}, lr, 32'h0001_FFFE);
        chk({tag, ".bclk_err"}, bclk_err, 0);
        chk({tag, ".und_start"}, und0, {31'd0, f.eu});
        chk({tag, ".und_extra"}, und_other, 0);
        chk({tag, ".ovr"}, ovr, f.eo);
    endtask

    // Release reset at a negedge and land on j=0 of the first frame.
    task automatic release_sync();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    frame_t tbl[11];
    frame_t zf;
    int     nb;

    initial begin
        tbl[0]  = '{10, 16'h8001, 16'h7FFE, -1, 16'h0, 16'h0,
                    16'h0000, 16'h0000, 1'b1, 0};
        tbl[1]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'h8001, 16'h7FFE, 1'b0, 0};
        tbl[2]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'h8001, 16'h7FFE, 1'b1, 0};
        tbl[3]  = '{20, 16'h1234, 16'h5678, 60, 16'hAAAA, 16'h5555,
                    16'h8001, 16'h7FFE, 1'b1, 1};
        tbl[4]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'hAAAA, 16'h5555, 1'b0, 0};
        tbl[5]  = '{127, 16'h0F0F, 16'hF0F0, -1, 16'h0, 16'h0,
                    16'hAAAA, 16'h5555, 1'b1, 0};
        tbl[6]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'hAAAA, 16'h5555, 1'b1, 0};
        tbl[7]  = '{50, 16'hC3C3, 16'h3C3C, 127, 16'h1111, 16'h2222,
                    16'h0F0F, 16'hF0F0, 1'b0, 0};
        tbl[8]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'hC3C3, 16'h3C3C, 1'b0, 0};
        tbl[9]  = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'h1111, 16'h2222, 1'b0, 0};
        tbl[10] = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'h1111, 16'h2222, 1'b1, 0};
        zf      = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0,
                    16'h0000, 16'h0000, 1'b1, 0};

        #1 rst_n = 1'b0;
        #20;
        chk("rst.bclk", bclk, 0);
        chk("rst.lrclk", lrclk, 0);
        chk("rst.sdata", sdata, 0);
        chk("rst.underrun", underrun, 0);
        chk("rst.overrun", overrun, 0);
`ifdef JT51_I2S_OVRCNT_EN
        chk("rst.ovr_cnt", ovr_cnt, 0);
`endif
        release_sync();

        for (int i = 0; i < 11; i++)
            run_frame($sformatf("F%0d", i), tbl[i]);

`ifdef JT51_I2S_OVRCNT_EN
        chk("ovr_cnt_after_table", ovr_cnt, 1);
`endif

        // Mid-frame reset at bit 18 (right slot of 2222): all three high.
        repeat (74) @(negedge clk);
        chk("pre_rst.bclk", bclk, 1);
        chk("pre_rst.lrclk", lrclk, 1);
        chk("pre_rst.sdata", sdata, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.bclk", bclk, 0);
        chk("mid_rst.lrclk", lrclk, 0);
        chk("mid_rst.sdata", sdata, 0);
        repeat (3) @(negedge clk);
        release_sync();
        run_frame("post_rst", zf);

        // Continuous strobes: every clk except the first and frame starts
        // overwrites a pending pair.
        nb = 0;
        left = 16'h0101;
        right = 16'h0202;
        sample_vld = 1'b1;
        for (int k = 0; k < 310; k++) begin
            @(negedge clk);
            if (overrun === 1'b1)
                nb++;
        end
        sample_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("burst_ovr_ge300", (nb >= 300) ? 1 : 0, 1);
`ifdef JT51_I2S_OVRCNT_EN
        chk("ovr_cnt_sat", ovr_cnt, 32'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
